// File: rtl/spi_master_rd.sv
// spi_master_rd: single-clock SPI master issuing one read transaction.
// Frame: 8-bit address on mosi, a cs-low idle gap for slave address decode,
// then an Nbit-bit data word captured from miso and returned in the clk domain.
`timescale 1ns/1ps

module spi_master_rd #(
    parameter int Nbit    = 8,
    parameter int CLK_DIV = 4,  // sclk half-period in clk cycles, >= 2
    parameter int GAP     = 8   // clk cycles of cs-low idle before data, >= 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [7:0]      adr,
    output logic            busy,
    output logic [Nbit-1:0] rx_data,
    output logic            rx_valid,
    output logic            sclk,
    output logic            mosi,
    input  logic            miso,
    output logic            cs
);

    localparam int HW = $clog2(CLK_DIV);
    localparam int GW = $clog2(GAP + 1);
    localparam int BW = $clog2((Nbit > 8) ? Nbit : 8);

    localparam logic [HW-1:0] HC_LAST   = HW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP - 1);
    localparam logic [BW-1:0] ABIT_LAST = BW'(7);
    localparam logic [BW-1:0] DBIT_LAST = BW'(Nbit - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ADDR,
        S_GAP,
        S_DATA,
        S_HOLD
    } state_t;

    state_t          state_q;
    logic [HW-1:0]   hc_q;        // half-period counter
    logic [GW-1:0]   gap_q;       // gap counter
    logic [BW-1:0]   bit_q;       // bit counter within ADDR / DATA
    logic [6:0]      adr_q;       // remaining address bits; adr[7] goes straight to mosi
    logic [Nbit-1:0] sh_q;        // data shift register
    logic            sclk_q;
    logic            mosi_q;
    logic            cs_q;
    logic            busy_q;
    logic            rx_valid_q;
    logic [Nbit-1:0] rx_data_q;
    logic            miso_s1_q;
    logic            miso_s2_q;

    logic            half_done;
    logic [HW-1:0]   hc_d;
    logic [Nbit-1:0] sh_d;

    assign busy     = busy_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign cs       = cs_q;

    // Next-value helpers shared by several FSM states.
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        half_done = (hc_q == HC_LAST);
        hc_d      = hc_q + 1'b1;
        sh_d      = sh_q << 1;
        sh_d[0]   = miso_s2_q;
    end

    // Two-flop synchronizer for miso, which is launched by the slave off sclk.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miso_s1_q <= 1'b0;
            miso_s2_q <= 1'b0;
        end else begin
            miso_s1_q <= miso;
            miso_s2_q <= miso_s1_q;
        end
    end

    // Transaction FSM; every SPI pin and status output is a register updated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            hc_q       <= '0;
            gap_q      <= '0;
            bit_q      <= '0;
            adr_q      <= '0;
            sh_q       <= '0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs_q       <= 1'b1;
            busy_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            rx_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // busy drops one cycle after rx_valid unless a new request arrives.
                    busy_q <= start;
                    if (start) begin
                        adr_q   <= adr[6:0];
                        mosi_q  <= adr[7];
                        cs_q    <= 1'b0;
                        hc_q    <= '0;
                        state_q <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    if (half_done) begin
                        hc_q    <= '0;
                        bit_q   <= '0;
                        sclk_q  <= 1'b1;
                        state_q <= S_ADDR;
                    end else begin
                        hc_q <= hc_d;
                    end
                end

                S_ADDR: begin
                    if (!half_done) begin
                        hc_q <= hc_d;
                    end else begin
                        hc_q <= '0;
                        if (sclk_q) begin
                            // Falling edge: present the next address bit, or idle mosi after the last.
                            sclk_q <= 1'b0;
                            mosi_q <= (bit_q == ABIT_LAST) ? 1'b0 : adr_q[6];
                            adr_q  <= {adr_q[5:0], 1'b0};
                        end else if (bit_q == ABIT_LAST) begin
                            // End of the 8th low half: the address phase is complete.
                            gap_q   <= '0;
                            state_q <= S_GAP;
                        end else begin
                            sclk_q <= 1'b1;
                            bit_q  <= bit_q + 1'b1;
                        end
                    end
                end

                S_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        hc_q    <= '0;
                        bit_q   <= '0;
                        sclk_q  <= 1'b1;
                        state_q <= S_DATA;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end

                S_DATA: begin
                    if (!half_done) begin
                        hc_q <= hc_d;
                    end else begin
                        hc_q <= '0;
                        if (sclk_q) begin
                            // Last cycle of the high half: the synchronizer delay makes this
                            // capture the bit the slave launched after the previous fall.
                            sclk_q <= 1'b0;
                            sh_q   <= sh_d;
                        end else if (bit_q == DBIT_LAST) begin
                            state_q <= S_HOLD;
                        end else begin
                            sclk_q <= 1'b1;
                            bit_q  <= bit_q + 1'b1;
                        end
                    end
                end

                S_HOLD: begin
                    if (half_done) begin
                        cs_q       <= 1'b1;
                        rx_data_q  <= sh_q;
                        rx_valid_q <= 1'b1;
                        state_q    <= S_IDLE;
                    end else begin
                        hc_q <= hc_d;
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_rd.sv
// tb_spi_master_rd: three spi_master_rd configurations, each against a
// behavioural SPI read slave. A driver issues directed reads and queues the
// expected word and arrival cycle; per-instance monitors pop and compare on rx_valid.
`timescale 1ns/1ps

module tb_spi_master_rd;

    // Configurations: 0 = defaults, 1 = GAP 3, 2 = CLK_DIV 2 / Nbit 16.
    function automatic int div_of(input int g);
        case (g)
            2:       return 2;
            default: return 4;
        endcase
    endfunction

    function automatic int nb_of(input int g);
        case (g)
            2:       return 16;
            default: return 8;
        endcase
    endfunction

    function automatic int gap_of(input int g);
        case (g)
            1:       return 3;
            default: return 8;
        endcase
    endfunction

    typedef struct {
        int          inst;
        logic [15:0] data;
        int          t;
        int          lat;
        logic [7:0]  adr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  adr = 8'h00;
    logic        start_w [3];
    logic        busy_w  [3];
    logic        cs_w    [3];
    logic        sclk_w  [3];
    logic        rxv_w   [3];
    logic [15:0] rxd_w   [3];
    logic [7:0]  slv_adr [3];
    logic [15:0] slv_word[3];

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int D  = div_of(g);
        localparam int NB = nb_of(g);
        localparam int GP = gap_of(g);

        logic          start, busy, rxv, sclk, mosi, cs;
        logic          miso;
        logic [NB-1:0] rxd;

        assign start     = start_w[g];
        assign busy_w[g] = busy;
        assign cs_w[g]   = cs;
        assign sclk_w[g] = sclk;
        assign rxv_w[g]  = rxv;
        assign rxd_w[g]  = 16'(rxd);

        spi_master_rd #(.Nbit(NB), .CLK_DIV(D), .GAP(GP)) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .start    (start),
            .adr      (adr),
            .busy     (busy),
            .rx_data  (rxd),
            .rx_valid (rxv),
            .sclk     (sclk),
            .mosi     (mosi),
            .miso     (miso),
            .cs       (cs)
        );

        // Behavioural read slave: shifts the address in on sclk rises, then on the
        // 8th fall drives the MSB of its word (all ones on address miss), one bit per fall.
        logic [7:0]    s_adr = 8'h00;
        int            s_rise = 0;
        logic [NB-1:0] s_word = '0;

        initial miso = 1'b0;

        always @(posedge sclk or negedge cs) begin
            if (!sclk) begin
                s_rise = 0;
                s_adr  = 8'h00;
            end else if (!cs) begin
                if (s_rise < 8) s_adr = {s_adr[6:0], mosi};
                s_rise++;
            end
        end

        always @(negedge sclk) begin
            if (!cs && s_rise >= 8) begin
                if (s_rise == 8)
                    s_word = (s_adr == slv_adr[g]) ? slv_word[g][NB-1:0] : '1;
                miso   = s_word[NB-1];
                s_word = s_word << 1;
            end
        end

        // Monitor: busy run length plus the queued expectation on every rx_valid.
        int   run = 0;
        exp_t e;

        always @(negedge clk) begin
            if (!rst_n) begin
                run = 0;
            end else begin
                run = busy ? run + 1 : 0;
                if (rxv) begin
                    if (exp_q.size() == 0 || exp_q[0].inst != g) begin
                        check("unexpected_rx_valid", 32'(rxv), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("rx_data",       32'(rxd_w[g]), 32'(e.data));
                        check("rx_valid_time", cyc,           e.t);
                        check("busy_run",      run,           e.lat + 1);
                        check("adr_on_mosi",   32'(s_adr),    32'(e.adr));
                        check("sclk_rises",    s_rise,        8 + NB);
                    end
                end
            end
        end
    end

    // One read on instance g; optionally pulses start at T0+10 and on the rx_valid edge.
    task automatic do_txn(input int g, input logic [7:0] a, input logic [7:0] sa,
                          input logic [15:0] sw, input logic [15:0] ed,
                          input int lat, input bit spurious);
        int t0;
        int hi;
        bit done;
        slv_adr[g]  = sa;
        slv_word[g] = sw;
        @(negedge clk);
        adr = a;
        start_w[g] = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        exp_q.push_back('{g, ed, t0 + lat, lat, a});
        check("cs_low_after_start", 32'(cs_w[g]),   32'd0);
        check("busy_after_start",   32'(busy_w[g]), 32'd1);
        @(negedge clk);
        start_w[g] = 1'b0;
        adr = 8'h00;
        done = 1'b0;
        for (int k = 0; k < lat + 50 && !done; k++) begin
            @(negedge clk);
            if (spurious) start_w[g] = (cyc == t0 + 9) || (cyc == t0 + lat - 1);
            if (!busy_w[g]) done = 1'b1;
        end
        start_w[g] = 1'b0;
        check("busy_dropped",   32'(busy_w[g]), 32'd0);
        check("busy_fall_time", cyc,            t0 + lat + 1);
        check("cs_idle",        32'(cs_w[g]),   32'd1);
        if (spurious) begin
            hi = 0;
            repeat (30) begin
                @(negedge clk);
                if (busy_w[g] || !cs_w[g]) hi++;
            end
            check("no_second_txn", hi, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        for (int g = 0; g < 3; g++) begin
            start_w[g]  = 1'b0;
            slv_adr[g]  = 8'h01;
            slv_word[g] = 16'h0000;
        end

        // Reset held: start toggling must not disturb the idle outputs.
        rst_n = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) start_w[g] = k[0];
        end
        for (int g = 0; g < 3; g++) begin
            check("rst_cs",       32'(cs_w[g]),   32'd1);
            check("rst_sclk",     32'(sclk_w[g]), 32'd0);
            check("rst_busy",     32'(busy_w[g]), 32'd0);
            check("rst_rx_valid", 32'(rxv_w[g]),  32'd0);
            check("rst_rx_data",  32'(rxd_w[g]),  32'd0);
            start_w[g] = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Directed reads: latency = CLK_DIV + 16*CLK_DIV + GAP + 2*Nbit*CLK_DIV + CLK_DIV.
        do_txn(0, 8'h01, 8'h01, 16'h00A5, 16'h00A5, 144, 1'b0);
        do_txn(0, 8'h02, 8'h01, 16'h00A5, 16'h00FF, 144, 1'b0);
        do_txn(1, 8'h01, 8'h01, 16'h003C, 16'h003C, 139, 1'b0);
        do_txn(2, 8'h01, 8'h01, 16'h1234, 16'h1234, 108, 1'b0);
        do_txn(0, 8'h5A, 8'h5A, 16'h00C3, 16'h00C3, 144, 1'b1);

        // Reset in the middle of the data phase, during an sclk high half.
        slv_adr[0]  = 8'h01;
        slv_word[0] = 16'h0096;
        @(negedge clk);
        adr = 8'h01;
        start_w[0] = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        @(negedge clk);
        start_w[0] = 1'b0;
        do begin
            @(posedge clk);
            #1;
        end while (cyc < t0 + 92);
        check("pre_rst_cs",   32'(cs_w[0]),   32'd0);
        check("pre_rst_sclk", 32'(sclk_w[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_cs",      32'(cs_w[0]),   32'd1);
        check("mid_rst_sclk",    32'(sclk_w[0]), 32'd0);
        check("mid_rst_busy",    32'(busy_w[0]), 32'd0);
        check("mid_rst_rx_data", 32'(rxd_w[0]),  32'd0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        check("post_rst_queue_empty", exp_q.size(), 0);

        // Recovery read on the wide configuration.
        do_txn(2, 8'h7F, 8'h7F, 16'hBEEF, 16'hBEEF, 108, 1'b0);

        repeat (5) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
